// File: rtl/i2c_target_resp_if.sv
// Bus bundle for the I2C register target: wired-bus inputs, open-drain
// drives, busy flag and the register-write event strobe.
interface i2c_target_resp_if #(
    parameter int I2C_DATA_WIDTH = 8,
    parameter int NUM_REGS       = 16
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                      scl_i;
    logic                      sda_i;
    logic                      scl_o;
    logic                      sda_o;
    logic                      busy_o;
    logic                      wr_valid_o;
    logic [IDX_W-1:0]          wr_idx_o;
    logic [I2C_DATA_WIDTH-1:0] wr_data_o;

    // Bus side (controller / environment)
    modport master (output scl_i, sda_i,
                    input  scl_o, sda_o, busy_o, wr_valid_o, wr_idx_o, wr_data_o);
    // Target side (this responder)
    modport slave  (input  scl_i, sda_i,
                    output scl_o, sda_o, busy_o, wr_valid_o, wr_idx_o, wr_data_o);
endinterface

// File: rtl/i2c_target_resp.sv
// I2C target with a small register file. A write sets the register
// pointer with its first byte and stores each following byte at the
// auto-incrementing pointer; a read streams registers from the pointer.
// SCL is never stretched; SDA changes only while SCL is low.
module i2c_target_resp #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
    parameter int                        NUM_REGS       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    i2c_target_resp_if.slave bus
);
    localparam int AW = I2C_ADDR_WIDTH;
    localparam int DW = I2C_DATA_WIDTH;
    localparam int PW = $clog2(NUM_REGS);
    localparam int SW = (DW > AW + 1) ? DW : AW + 1;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      scl_sync, sda_sync;
    logic            scl_d, sda_d, scl_s, sda_s;
    logic            scl_rise, scl_fall, start_c, stop_c;
    logic [SW-2:0]   sreg;
    logic [SW-1:0]   sreg_nx;
    logic [CW-1:0]   bit_cnt;
    logic [1:0]      ack_ph;     // ACK sub-phase, see ACK state handling
    logic            rw_q;
    logic            addr_hit, addr_last, data_last;
    logic [DW-2:0]   tx;         // read bits still to be shifted out
    logic [PW-1:0]   ptr;
    logic [DW-1:0]   regs [NUM_REGS];
    logic [DW-1:0]   byte_in, rd_byte;
    logic            sda_q, busy_q, wr_valid_q;
    logic [PW-1:0]   wr_idx_q;
    logic [DW-1:0]   wr_data_q;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_c   = scl_s & sda_d & ~sda_s;
    assign stop_c    = scl_s & ~sda_d & sda_s;

    assign sreg_nx   = {sreg, sda_s};
    assign byte_in   = sreg_nx[DW-1:0];
    assign addr_hit  = (sreg_nx[AW:1] == TARGET_ADDR);
    assign rd_byte   = regs[ptr];
    assign addr_last = scl_rise && (bit_cnt == ADDR_LAST);
    assign data_last = scl_rise && (bit_cnt == DATA_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state; STOP and (repeated) START override everything
    always_comb begin
        state_nx = state;
        if (stop_c)       state_nx = S_IDLE;
        else if (start_c) state_nx = S_ADDR;
        else begin
            case (state)
                S_ADDR:      if (addr_last) state_nx = addr_hit ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (scl_fall && ack_ph != 2'd0) state_nx = rw_q ? S_RDATA : S_PTR;
                S_PTR:       if (data_last) state_nx = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall && ack_ph != 2'd0) state_nx = S_WDATA;
                S_WDATA:     if (data_last) state_nx = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && ack_ph != 2'd0) state_nx = S_WDATA;
                S_RDATA:     if (data_last) state_nx = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (scl_rise && ack_ph == 2'd1 && sda_s)   state_nx = S_IGNORE;
                    else if (scl_fall && ack_ph == 2'd2)       state_nx = S_RDATA;
                end
                default: ;
            endcase
        end
    end

    // Datapath: bit shifting, ACK drive, pointer, register file, write strobe
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            ack_ph     <= 2'd0;
            rw_q       <= 1'b0;
            tx         <= '0;
            ptr        <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_c) begin
                sda_q   <= 1'b1;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
                ack_ph  <= 2'd0;
            end else if (start_c) begin
                // partial byte is dropped; busy survives a repeated START
                sda_q   <= 1'b1;
                bit_cnt <= '0;
                ack_ph  <= 2'd0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        sreg    <= sreg_nx[SW-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (addr_last) begin
                            bit_cnt <= '0;
                            ack_ph  <= 2'd0;
                            rw_q    <= sreg_nx[0];
                            busy_q  <= addr_hit;
                        end
                    end
                    S_PTR, S_WDATA: if (scl_rise) begin
                        sreg    <= sreg_nx[SW-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (data_last) begin
                            bit_cnt <= '0;
                            ack_ph  <= 2'd0;
                            if (state == S_PTR) begin
                                ptr <= byte_in[PW-1:0];
                            end else begin
                                regs[ptr]  <= byte_in;
                                wr_valid_q <= 1'b1;
                                wr_idx_q   <= ptr;
                                wr_data_q  <= byte_in;
                                ptr        <= ptr + 1'b1;
                            end
                        end
                    end
                    // phase 0: pull SDA low at the fall after bit 8;
                    // phase 1: release (or present read MSB) at the fall ending ACK
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (ack_ph == 2'd0) begin
                            sda_q  <= 1'b0;
                            ack_ph <= 2'd1;
                        end else begin
                            ack_ph  <= 2'd0;
                            bit_cnt <= '0;
                            if (state == S_ADDR_ACK && rw_q) begin
                                sda_q <= rd_byte[DW-1];
                                tx    <= rd_byte[DW-2:0];
                            end else begin
                                sda_q <= 1'b1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            sda_q <= tx[DW-2];
                            tx    <= {tx[DW-3:0], 1'b0};
                        end
                        if (scl_rise) bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
                    end
                    // phase 0: release SDA; phase 1: sample controller ACK;
                    // phase 2: present next byte's MSB at the fall ending ACK
                    S_RDATA_ACK: begin
                        if (scl_fall && ack_ph == 2'd0) begin
                            sda_q  <= 1'b1;
                            ack_ph <= 2'd1;
                        end else if (scl_rise && ack_ph == 2'd1) begin
                            if (!sda_s) begin
                                ptr    <= ptr + 1'b1;
                                ack_ph <= 2'd2;
                            end else begin
                                ack_ph <= 2'd0;
                            end
                        end else if (scl_fall && ack_ph == 2'd2) begin
                            ack_ph  <= 2'd0;
                            bit_cnt <= '0;
                            sda_q   <= rd_byte[DW-1];
                            tx      <= rd_byte[DW-2:0];
                        end
                    end
                    default: sda_q <= 1'b1;
                endcase
            end
        end
    end

    assign bus.scl_o      = 1'b1;
    assign bus.sda_o      = sda_q;
    assign bus.busy_o     = busy_q;
    assign bus.wr_valid_o = wr_valid_q;
    assign bus.wr_idx_o   = wr_idx_q;
    assign bus.wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_resp.sv
// Bench for i2c_target_resp: bit-banged I2C controller, register-file
// model with a persistent pointer, and a write-event scoreboard.
module tb_i2c_target_resp;
    localparam int Q    = 5;   // clocks per quarter of an SCL bit slot
    localparam int NREG = 16;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_c = 1'b1;
    logic sda_c = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    i2c_target_resp_if #(.I2C_DATA_WIDTH(8), .NUM_REGS(NREG)) bus();
    assign bus.scl_i = scl_c;
    assign bus.sda_i = sda_c & bus.sda_o;   // wired-AND line

    i2c_target_resp dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // reference model
    logic [7:0] m_regs [NREG];
    int         m_ptr;
    int         exp_idx[$], exp_dat[$], got_idx[$], got_dat[$];
    int         dbl = 0;
    logic       wv_prev = 1'b0;

    // collect write events and flag strobes longer than one cycle
    always @(negedge clk) begin
        if (bus.wr_valid_o) begin
            got_idx.push_back(int'(bus.wr_idx_o));
            got_dat.push_back(int'(bus.wr_data_o));
            if (wv_prev) dbl <= dbl + 1;
        end
        wv_prev <= bus.wr_valid_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; hq(); scl_c = 1'b1; hq(); sda_c = 1'b0; hq(); scl_c = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; hq(); scl_c = 1'b1; hq(); sda_c = 1'b1; hq(); hq();
    endtask

    task automatic wbit(input logic b);
        sda_c = b; hq(); scl_c = 1'b1; hq(); scl_c = 1'b0; hq();
    endtask

    task automatic rbit(output logic b);
        sda_c = 1'b1; hq(); scl_c = 1'b1; hq(); b = bus.sda_i; scl_c = 1'b0; hq();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(~ack);
    endtask

    task automatic check_writes();
        chk("wr_count", got_idx.size(), exp_idx.size());
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
            chk("wr_idx", got_idx[i], exp_idx[i]);
            chk("wr_data", got_dat[i], exp_dat[i]);
        end
        got_idx.delete(); got_dat.delete(); exp_idx.delete(); exp_dat.delete();
    endtask

    task automatic tx_write(input logic [7:0] p, input bq_t dat);
        logic a;
        i2c_start();
        wbyte(8'h44, a);  chk("w_addr_ack", a, 1);
        chk("busy_on", bus.busy_o, 1);
        wbyte(p, a);      chk("w_ptr_ack", a, 1);
        m_ptr = int'(p) % NREG;
        foreach (dat[k]) begin
            wbyte(dat[k], a); chk("w_data_ack", a, 1);
            exp_idx.push_back(m_ptr);
            exp_dat.push_back(int'(dat[k]));
            m_regs[m_ptr] = dat[k];
            m_ptr = (m_ptr + 1) % NREG;
        end
        i2c_stop();
        chk("busy_off", bus.busy_o, 0);
        check_writes();
    endtask

    // read n bytes (ACK all but the last), then one more byte in IGNORE
    task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic a;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            wbyte(8'h44, a); chk("r_waddr_ack", a, 1);
            wbyte(p, a);     chk("r_ptr_ack", a, 1);
            m_ptr = int'(p) % NREG;
            i2c_start();
        end
        wbyte(8'h45, a); chk("r_addr_ack", a, 1);
        for (int k = 0; k < n; k++) begin
            rbyte(d, k < n - 1);
            chk("rd_data", d, m_regs[m_ptr]);
            if (k < n - 1) m_ptr = (m_ptr + 1) % NREG;
        end
        rbyte(d, 1'b1);
        chk("ignore_released", d, 8'hFF);
        i2c_stop();
        chk("busy_off_r", bus.busy_o, 0);
        check_writes();
    endtask

    task automatic tx_bad(input logic [6:0] adr, input logic rw);
        logic a;
        i2c_start();
        wbyte({adr, rw}, a);            chk("bad_nack", a, 0);
        chk("bad_busy", bus.busy_o, 0);
        wbyte(8'($urandom), a);         chk("bad_data_nack", a, 0);
        i2c_stop();
        check_writes();
    endtask

    // STOP after nb data bits (the STOP's own SCL rise adds one more bit)
    task automatic tx_abort(input logic [7:0] p, input int nb);
        logic a;
        i2c_start();
        wbyte(8'h44, a); chk("ab_addr_ack", a, 1);
        wbyte(p, a);     chk("ab_ptr_ack", a, 1);
        m_ptr = int'(p) % NREG;
        repeat (nb) wbit(1'($urandom));
        i2c_stop();
        chk("ab_busy", bus.busy_o, 0);
        chk("ab_sda", bus.sda_o, 1);
        check_writes();
    endtask

    initial begin
        bq_t q;
        logic a;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_sda", bus.sda_o, 1);
        chk("rst_scl", bus.scl_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_wv", bus.wr_valid_o, 0);
        chk("rst_idx", bus.wr_idx_o, 0);
        chk("rst_data", bus.wr_data_o, 0);
        rst_n = 1'b1;
        hq();

        // basic write, wrap, read-back
        q = '{8'hA5, 8'h5A};  tx_write(8'h03, q);
        q = '{8'h11, 8'h22};  tx_write(8'h0F, q);
        tx_read(1'b1, 8'h0F, 2);
        tx_read(1'b1, 8'h02, 2);
        tx_bad(7'h23, 1'b0);
        tx_abort(8'h07, 4);
        tx_read(1'b0, 8'h00, 1);

        // randomized transactions
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 4))
                0: begin
                    q = {};
                    repeat ($urandom_range(0, 4)) q.push_back(8'($urandom));
                    tx_write(8'($urandom), q);
                end
                1: tx_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
                2: tx_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
                3: begin
                    logic [6:0] ad;
                    ad = 7'($urandom);
                    if (ad == 7'h22) ad = 7'h23;
                    tx_bad(ad, 1'($urandom));
                end
                default: tx_abort(8'($urandom), int'($urandom_range(1, 6)));
            endcase
            chk("scl_rel", bus.scl_o, 1);
        end
        chk("wv_one_cycle", dbl, 0);

        // reset while the target is driving a 0 read bit
        q = '{8'h3C};  tx_write(8'h05, q);
        i2c_start();
        wbyte(8'h44, a); wbyte(8'h05, a);
        i2c_start();
        wbyte(8'h45, a); chk("rr_addr_ack", a, 1);
        chk("rr_drive_low", bus.sda_o, 0);
        #1 rst_n = 1'b0;
        #1 chk("rr_async_rel", bus.sda_o, 1);
        chk("rr_busy", bus.busy_o, 0);
        sda_c = 1'b1; hq(); scl_c = 1'b1; hq();
        rst_n = 1'b1;
        model_reset();
        hq();
        tx_read(1'b0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
